fp_rsp_arbiter: RTL and testbench

- Merges the result streams of the FP units (sqrt, div, fma, cvt, ...) into the single FPU writeback/commit port.
- Each unit's valid/tag/result output and ready_out input connect to one arbiter input. The arbiter's backpressure drives that unit's pipeline stall.
- Round-robin arbitration feeds a 2-entry elastic output buffer, so one response per cycle is sustained under continuous ready.

---
 rtl/fp_rsp_arbiter_if.sv | 32 +++
 rtl/fp_rsp_arbiter.sv | 113 +++++++++++
 tb/tb_fp_rsp_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_rsp_arbiter_if.sv
// Response bus between the FP unit result streams and the FPU writeback port.
// slave  : arbiter side (consumes unit responses, produces the merged stream)
// master : producer/consumer side (FP units and the writeback stage)
//   valid_in/tag_in/data_in : per-unit response, ready_in : per-unit accept
//   valid_out/tag_out/result/sel_out : merged head response, ready_out : downstream accept
interface fp_rsp_arbiter_if #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned TAGW       = 1,
    parameter int unsigned LANES      = 1
);
    localparam int unsigned SELW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [NUM_INPUTS-1:0]          valid_in;
    logic [NUM_INPUTS-1:0]          ready_in;
    logic [NUM_INPUTS*TAGW-1:0]     tag_in;
    logic [NUM_INPUTS*LANES*32-1:0] data_in;
    logic                           valid_out;
    logic                           ready_out;
    logic [TAGW-1:0]                tag_out;
    logic [LANES*32-1:0]            result;
    logic [SELW-1:0]                sel_out;

    modport slave (
        input  valid_in, tag_in, data_in, ready_out,
        output ready_in, valid_out, tag_out, result, sel_out
    );

    modport master (
        output valid_in, tag_in, data_in, ready_out,
        input  ready_in, valid_out, tag_out, result, sel_out
    );
endinterface

// File: rtl/fp_rsp_arbiter.sv
// Round-robin merge of FP unit response streams into one writeback port,
// followed by a 2-entry elastic buffer for full throughput.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   rsp   : fp_rsp_arbiter_if.slave (unit inputs, merged output, handshakes)
module fp_rsp_arbiter #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned TAGW       = 1,
    parameter int unsigned LANES      = 1,
    localparam int unsigned SELW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input logic               clk,
    input logic               reset,
    fp_rsp_arbiter_if.slave   rsp
);
    localparam int unsigned DW = LANES * 32;

    // Candidate index k steps after base, wrapping modulo NUM_INPUTS.
    function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base,
                                                 input int unsigned k);
        return SELW'((32'(base) + k) % NUM_INPUTS);
    endfunction

    logic [SELW-1:0]       last_grant_q, last_grant_d;
    logic [SELW-1:0]       grant_idx;
    logic                  grant_any;
    logic [NUM_INPUTS-1:0] grant;

    logic [1:0]            count_q, count_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [SELW-1:0]       sel_q  [2];
    logic [TAGW-1:0]       tag_q  [2];
    logic [DW-1:0]         data_q [2];

    logic                  can_push;
    logic                  push;
    logic                  pop;
    logic [TAGW-1:0]       push_tag;
    logic [DW-1:0]         push_data;

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
            if (!grant_any && rsp.valid_in[wrap_idx(last_grant_q, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_idx(last_grant_q, k);
            end
        end
        grant            = '0;
        grant[grant_idx] = grant_any;
    end

    // Full blocks pushes even when a pop happens in the same cycle, which keeps
    // ready_in independent of ready_out.
    assign can_push  = (count_q != 2'd2);
    assign push      = grant_any & can_push;
    assign pop       = (count_q != 2'd0) & rsp.ready_out;
    assign push_tag  = rsp.tag_in[32'(grant_idx) * TAGW +: TAGW];
    assign push_data = rsp.data_in[32'(grant_idx) * DW +: DW];

    assign rsp.ready_in  = grant & {NUM_INPUTS{can_push}};
    assign rsp.valid_out = (count_q != 2'd0);
    assign rsp.tag_out   = tag_q[head_q];
    assign rsp.result    = data_q[head_q];
    assign rsp.sel_out   = sel_q[head_q];

    always_comb begin
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        last_grant_d = last_grant_q;
        if (push) begin
            tail_d       = ~tail_q;
            last_grant_d = grant_idx;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= 2'd0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            last_grant_q <= SELW'(NUM_INPUTS - 1);
            for (int i = 0; i < 2; i++) begin
                sel_q[i]  <= '0;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            last_grant_q <= last_grant_d;
            if (push) begin
                sel_q[tail_q]  <= grant_idx;
                tag_q[tail_q]  <= push_tag;
                data_q[tail_q] <= push_data;
            end
        end
    end
endmodule

// File: tb/tb_fp_rsp_arbiter.sv
module tb_fp_rsp_arbiter;
    logic clk = 1'b0;
    logic reset;

    fp_rsp_arbiter_if #(.NUM_INPUTS(4), .TAGW(1), .LANES(1)) ifc();

    fp_rsp_arbiter #(.NUM_INPUTS(4), .TAGW(1), .LANES(1)) dut (
        .clk   (clk),
        .reset (reset),
        .rsp   (ifc)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of accepted responses plus the last granted index.
    typedef struct {
        int          sel;
        logic        tag;
        logic [31:0] data;
    } rsp_t;

    rsp_t q[$];
    int   lg;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [3:0] model_grant(input logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (lg + k) % 4;
            if (v[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    function automatic logic [3:0] model_ready();
        return (q.size() < 2) ? model_grant(ifc.valid_in) : 4'b0000;
    endfunction

    task automatic model_reset();
        q.delete();
        lg = 3;
    endtask

    task automatic drive(input logic [3:0] v, input logic ro);
        ifc.valid_in  = v;
        ifc.ready_out = ro;
        ifc.tag_in    = 4'($urandom);
        ifc.data_in   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Advance one clock, updating the model with what the edge should do.
    task automatic tick();
        logic [3:0] g;
        bit         do_pop;
        rsp_t       e;
        g      = model_ready();
        do_pop = (q.size() > 0) && ifc.ready_out;
        e      = '{sel: 0, tag: 1'b0, data: 32'h0};
        for (int k = 0; k < 4; k++) begin
            if (g[k]) begin
                e.sel  = k;
                e.tag  = ifc.tag_in[k];
                e.data = ifc.data_in[k*32 +: 32];
            end
        end
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (g != 4'b0000) begin
            q.push_back(e);
            lg = e.sel;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(4'b0000, 1'b0);
        reset = 1'b1;
        model_reset();
        #3;
        n_tests++;
        if (ifc.valid_out !== 1'b0 || ifc.tag_out !== 1'b0 || ifc.result !== 32'h0 ||
            ifc.sel_out !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b t=%b r=%h s=%0d want all 0",
                     ifc.valid_out, ifc.tag_out, ifc.result, ifc.sel_out);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        n_tests++;
        if (ifc.valid_out !== 1'b0 || ifc.result !== 32'h0 || ifc.ready_in !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: got v=%b r=%h rdy=%b want 0/0/0000",
                     ifc.valid_out, ifc.result, ifc.ready_in);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive(4'b0001, 1'b1);
        ifc.tag_in[0]       = 1'b1;
        ifc.data_in[31:0]   = 32'h3F800000;
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0001", ifc.ready_in);
        end
        tick();
        drive(4'b0000, 1'b1);
        n_tests++;
        if (ifc.valid_out !== 1'b1 || ifc.result !== 32'h3F800000 || ifc.tag_out !== 1'b1 ||
            ifc.sel_out !== 2'd0) begin
            n_fail++;
            $display("FAIL single_out: got v=%b r=%h t=%b s=%0d want 1/3f800000/1/0",
                     ifc.valid_out, ifc.result, ifc.tag_out, ifc.sel_out);
        end
        tick();
        n_tests++;
        if (ifc.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got valid_out=%b want 0", ifc.valid_out);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(4'b1111, 1'b1);
            #1;
            n_tests++;
            if (ifc.ready_in !== (4'b0001 << (i % 4))) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, ifc.ready_in,
                         4'b0001 << (i % 4));
            end
            tick();
            n_tests++;
            if (ifc.valid_out !== 1'b1 || ifc.sel_out !== 2'(i % 4) ||
                ifc.result !== q[0].data) begin
                n_fail++;
                $display("FAIL rr_out[%0d]: got v=%b s=%0d r=%h want 1/%0d/%h", i,
                         ifc.valid_out, ifc.sel_out, ifc.result, i % 4, q[0].data);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(4'b0110, 1'b0);
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_first: got %b want 0010", ifc.ready_in);
        end
        tick();
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_second: got %b want 0100", ifc.ready_in);
        end
        tick();
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b0000 || ifc.sel_out !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_full: got rdy=%b s=%0d want 0000/1", ifc.ready_in, ifc.sel_out);
        end
        tick();
        n_tests++;
        if (ifc.valid_out !== 1'b1 || ifc.sel_out !== 2'd1 || ifc.result !== q[0].data) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b s=%0d r=%h want 1/1/%h",
                     ifc.valid_out, ifc.sel_out, ifc.result, q[0].data);
        end
        ifc.ready_out = 1'b1;
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_full_pop: got %b want 0000", ifc.ready_in);
        end
        tick();
        #1;
        n_tests++;
        if (ifc.sel_out !== 2'd2 || ifc.ready_in !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_after_pop: got s=%0d rdy=%b want 2/0010",
                     ifc.sel_out, ifc.ready_in);
        end
        tick();
        n_tests++;
        if (ifc.sel_out !== 2'd1 || ifc.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_refill: got s=%0d v=%b want 1/1", ifc.sel_out, ifc.valid_out);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] b;
        do_reset();
        drive(4'b0001, 1'b1);
        tick();
        drive(4'b0010, 1'b1);
        b = ifc.data_in[63:32];
        tick();
        n_tests++;
        if (ifc.valid_out !== 1'b1 || ifc.sel_out !== 2'd1 || ifc.result !== b) begin
            n_fail++;
            $display("FAIL pushpop_head: got v=%b s=%0d r=%h want 1/1/%h",
                     ifc.valid_out, ifc.sel_out, ifc.result, b);
        end
        drive(4'b0000, 1'b1);
        tick();
        n_tests++;
        if (ifc.valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_count: got valid_out=%b want 0", ifc.valid_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(4'b1111, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (ifc.valid_out !== 1'b0 || ifc.sel_out !== 2'd0 || ifc.result !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b s=%0d r=%h want 0/0/0",
                     ifc.valid_out, ifc.sel_out, ifc.result);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, 1'b1);
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b0001) begin
            n_fail++;
            $display("FAIL async_regrant: got %b want 0001", ifc.ready_in);
        end
        tick();
        n_tests++;
        if (ifc.sel_out !== 2'd0 || ifc.valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL async_first: got s=%0d v=%b want 0/1", ifc.sel_out, ifc.valid_out);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b1000, 1'b1);
            #1;
            n_tests++;
            if (ifc.ready_in !== 4'b1000) begin
                n_fail++;
                $display("FAIL wrap_only3[%0d]: got %b want 1000", i, ifc.ready_in);
            end
            tick();
        end
        drive(4'b1001, 1'b1);
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_to0: got %b want 0001", ifc.ready_in);
        end
        tick();
        #1;
        n_tests++;
        if (ifc.ready_in !== 4'b1000 || ifc.sel_out !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_to3: got rdy=%b s=%0d want 1000/0", ifc.ready_in, ifc.sel_out);
        end
        tick();
        n_tests++;
        if (ifc.sel_out !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_out3: got %0d want 3", ifc.sel_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), $urandom_range(0, 3) != 0);
            #1;
            n_tests++;
            if (ifc.ready_in !== model_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, ifc.ready_in,
                         model_ready());
            end
            tick();
            n_tests++;
            if (ifc.valid_out !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b want %b", i, ifc.valid_out,
                         q.size() != 0);
            end else if (q.size() != 0) begin
                n_tests++;
                if (ifc.sel_out !== 2'(q[0].sel) || ifc.tag_out !== q[0].tag ||
                    ifc.result !== q[0].data) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d]: got s=%0d t=%b r=%h want %0d/%b/%h", i,
                             ifc.sel_out, ifc.tag_out, ifc.result, q[0].sel, q[0].tag,
                             q[0].data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
